// File: rtl/ps2_key_decoder.sv
// Purpose : PS/2 keyboard receiver. It frames 11-bit serial words (start, 8 data bits LSB first,
//           odd parity, stop) and tracks the scancode of the key currently held down.
// Latency : key_code/key_strobe update 1 cycle after the stop bit is sampled. The stop bit is sampled
//           3 cycles after the ps2_clk pin falls: two synchronizer flops plus one edge stage.
// Backpres: none. The PS/2 device owns the timing, and every accepted byte is consumed on the next cycle.
//
// Ports
//   clock        system clock; all logic runs on its rising edge
//   reset_signal asynchronous, active-low reset
//   ps2_clk      raw PS/2 clock pin, asynchronous to clock
//   ps2_data     raw PS/2 data pin, asynchronous to clock
//   key_code     scancode of the held key, 8'h00 when no key is held
//   key_strobe   one-cycle pulse when a make code loads key_code (typematic repeats included)
//   frame_error  one-cycle pulse when a frame is discarded (bad stop bit, timeout, optional parity)
//
// Configuration
//   PS2_PARITY_CHECK_EN  when defined, frames failing odd parity are discarded with frame_error.
//                        When undefined, the parity bit is captured and then ignored.

module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_signal,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_strobe,
  output logic       frame_error
);

  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Pin synchronizers. Stage 3 of the clock chain is only edge history;
  // the value on the data chain is already two flops deep when it is sampled.
  // ---------------------------------------------------------------------------
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic ps2_fall;

  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign ps2_fall = clk_s3 & ~clk_s2;

  // ---------------------------------------------------------------------------
  // Frame datapath registers
  // ---------------------------------------------------------------------------
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          parity_ok;
  logic          frame_ok;
  logic          frame_bad;
  logic          byte_vld;
  logic          break_pending;

  // A falling edge in the same cycle always wins over the timeout.
  assign timeout_hit = ~ps2_fall && (state != IDLE) && (to_cnt == TO_MAX);

`ifdef PS2_PARITY_CHECK_EN
  // Odd parity: data bits plus the parity bit must hold an odd number of ones.
  assign parity_ok = ^{shift_reg, parity_bit};
`else
  logic unused_parity;
  assign unused_parity = parity_bit;
  assign parity_ok     = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state and frame verdict
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;

    case (state)
      IDLE: begin
        // A falling edge with data high is noise, not a start bit. Ignore it silently.
        if (ps2_fall && !dat_s2) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (ps2_fall && (bit_cnt == 3'd7)) begin
          state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (ps2_fall) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (ps2_fall) begin
          state_nxt = IDLE;
          if (dat_s2 && parity_ok) begin
            frame_ok  = 1'b1;
          end else begin
            frame_bad = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_nxt = IDLE;
      frame_bad = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit capture and inactivity timer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (ps2_fall) begin
        case (state)
          IDLE: begin
            if (!dat_s2) begin
              bit_cnt   <= 3'd0;
              shift_reg <= 8'h00;
            end
          end
          DATA: begin
            shift_reg[bit_cnt] <= dat_s2;
            bit_cnt            <= bit_cnt + 3'd1;
          end
          PARITY: begin
            parity_bit <= dat_s2;
          end
          default: begin
          end
        endcase
      end

      if (ps2_fall || (state == IDLE) || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Byte hand-off. shift_reg is not touched again until the next start bit.
  // The start bit is sampled on a later edge than the one that consumes byte_vld,
  // so reading shift_reg directly on the following cycle is safe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      byte_vld    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      byte_vld    <= frame_ok;
      frame_error <= frame_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Scancode interpretation.
  //   E0 (extended prefix): dropped, so E0 xx behaves like xx and E0 F0 xx like F0 xx.
  //   F0 arms break. The next ordinary byte releases the key only if it matches the held key.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      key_code      <= 8'h00;
      key_strobe    <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (byte_vld) begin
        if (shift_reg == CODE_EXT) begin
          // prefix only
        end else if (shift_reg == CODE_BREAK) begin
          break_pending <= 1'b1;
        end else if (break_pending) begin
          break_pending <= 1'b0;
          if (shift_reg == key_code) begin
            key_code <= 8'h00;
          end
        end else begin
          key_code   <= shift_reg;
          key_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Purpose : self-checking bench for ps2_key_decoder. It sends directed and random PS/2 frames,
//           and a behavioural scancode model predicts the results.
// Latency : make-code strobe expected 4 clock cycles after the stop-bit ps2_clk fall is driven.
// Backpres: n/a.

module tb_ps2_key_decoder;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;      // system cycles per half PS/2 clock period

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clock;
  logic       reset_signal;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_strobe;
  logic       frame_error;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock       (clock),
    .reset_signal(reset_signal),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_code    (key_code),
    .key_strobe  (key_strobe),
    .frame_error (frame_error)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  // pulse observers
  int n_strobe   = 0;
  int n_err      = 0;
  int strobe_cyc = 0;
  int stop_cyc   = 0;
  always @(negedge clock) begin
    if (key_strobe) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
    if (frame_error) n_err++;
  end

  // reference model state
  logic [7:0] m_key = 8'h00;
  bit         m_brk = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output int strobe);
    strobe = 0;
    if (b == 8'hE0) begin
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (m_brk) begin
      m_brk = 1'b0;
      if (b == m_key) m_key = 8'h00;
    end else begin
      m_key  = b;
      strobe = 1;
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit bad_par, input bit stop);
    logic p;
    p = (~^b) ^ bad_par;           // odd parity unless deliberately corrupted
    return {stop, p, b, 1'b0};
  endfunction

  // Drives bits[0..nbits-1]. The gap adds extra idle cycles after bit index 4.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clock);
      #2;
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(posedge clock);
      #2;
      ps2_clk = 1'b1;
      if (i == 4) repeat (gap) @(posedge clock);
    end
  endtask

  // kind 0: normal frame. kind 1: start + 4 data bits, then silence. kind 2: near-timeout stall.
  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit stop, input int kind);
    int s0, e0, exp_s, exp_e;
    s0 = n_strobe;
    e0 = n_err;
    exp_s = 0;
    exp_e = 0;
    if (kind == 1 || !stop || (bad_par && PAR_EN)) exp_e = 1;
    else model_byte(b, exp_s);

    if (kind == 1) begin
      send_bits(mk(b, bad_par, stop), 5, 0);
      repeat (TIMEOUT + 40) @(posedge clock);
    end else begin
      send_bits(mk(b, bad_par, stop), 11, (kind == 2) ? TIMEOUT - 40 : 0);
      repeat (20) @(posedge clock);
    end
    @(negedge clock);
    check("key_code", key_code, m_key);
    check("strobe_count", n_strobe - s0, exp_s);
    check("error_count", n_err - e0, exp_e);
    if (exp_s == 1) check("strobe_latency", strobe_cyc - stop_cyc, 4);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fr;
    int r;
    logic [7:0] b;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    reset_signal = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_key_code", key_code, 8'h00);
    check("rst_strobe", key_strobe, 0);
    check("rst_error", frame_error, 0);
    reset_signal = 1'b1;
    repeat (5) @(posedge clock);

    // noise: a single clock pulse while data is high must be ignored silently
    r = n_err;
    send_bits(11'h7FF, 1, 0);
    repeat (20) @(posedge clock);
    check("noise_no_error", n_err - r, 0);

    do_frame(8'h3C, 0, 1, 0);              // make
    do_frame(8'hF0, 0, 1, 0);              // break of held key
    do_frame(8'h3C, 0, 1, 0);
    do_frame(8'h3C, 0, 1, 0);              // make again
    do_frame(8'hF0, 0, 1, 0);              // break of a different key
    do_frame(8'h1C, 0, 1, 0);
    do_frame(8'h1C, 0, 1, 0);              // now a make
    do_frame(8'h1C, 0, 1, 0);              // typematic repeat
    do_frame(8'h3C, 1, 1, 0);              // wrong parity
    do_frame(8'hE0, 0, 1, 0);              // extended prefix
    do_frame(8'h75, 0, 1, 0);
    do_frame(8'h55, 0, 0, 0);              // bad stop bit
    do_frame(8'h3C, 0, 1, 1);              // truncated -> timeout
    do_frame(8'h1C, 0, 1, 0);
    do_frame(8'h5A, 0, 1, 2);              // stall just under the timeout

    for (int n = 0; n < 45; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: b = 8'hF0;
        2:    b = 8'hE0;
        3:    b = m_key;
        4:    b = 8'h3C;
        5:    b = 8'h1C;
        default: b = 8'($urandom);
      endcase
      r = $urandom_range(0, 23);
      do_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0),
               (r == 0) ? 1 : ((r == 1) ? 2 : 0));
    end

    // reset in the middle of a frame, with a key held and a break pending
    do_frame(8'h3C, 0, 1, 0);
    do_frame(8'hF0, 0, 1, 0);
    fr = mk(8'h3C, 0, 1);
    send_bits(fr, 6, 0);
    ps2_data = fr[6];                      // data bit 5
    repeat (HALF) @(posedge clock);
    #2;
    ps2_clk = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    r = n_strobe;
    reset_signal = 1'b0;
    #1;
    check("midrst_key_code", key_code, 8'h00);
    check("midrst_strobe", key_strobe, 0);
    check("midrst_error", frame_error, 0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    reset_signal = 1'b1;
    m_key = 8'h00;
    m_brk = 1'b0;
    repeat (5) @(posedge clock);
    check("midrst_no_strobe", n_strobe - r, 0);
    do_frame(8'h3C, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, clock cycles of ps2_clk inactivity mid-frame before abort (1 ms at 50 MHz).
REQ-002 clock  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-003 reset_signal  input  1  reset, asynchronous, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clock.
REQ-005 ps2_data  input  1  raw PS/2 data pin, asynchronous to clock.
REQ-006 key_code  output  8  scancode of the currently held key, 8'h00 when no key held; feeds the user_input port of each column.
REQ-007 key_strobe  output  1  one-cycle pulse when key_code is loaded by a make code.
REQ-008 frame_error  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge SHALL be detected from synchronized ps2_clk stages 2 and 3.
REQ-010 All frame bits SHALL be sampled from synchronized ps2_data on the cycle a ps2_clk falling edge is detected.
REQ-011 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: on falling edge with data 0 go to DATA, bit count 0; data 1 stays IDLE with no error.
REQ-013 DATA: each falling edge shifts data into bit [count] of the shift register (LSB first); after bit 7 go to PARITY.
REQ-014 PARITY: sample parity bit, go to STOP.
REQ-015 STOP: sample stop bit, return to IDLE; stop bit 0 SHALL discard the frame and pulse frame_error.
REQ-016 Timeout counter SHALL clear on every falling edge and count in any state except IDLE; reaching TIMEOUT_CYCLES SHALL return FSM to IDLE, discard the partial frame and pulse frame_error.
REQ-017 An accepted byte SHALL be processed the cycle after the stop bit is sampled.
REQ-018 Byte 8'hE0: SHALL be discarded, no output change; the following byte is processed normally.
REQ-019 Byte 8'hF0: SHALL set a break_pending flag, no output change.
REQ-020 Any other byte with break_pending set: clear break_pending; if byte equals key_code, key_code SHALL become 8'h00; otherwise key_code unchanged; no key_strobe.
REQ-021 Any other byte with break_pending clear: key_code SHALL load byte and key_strobe SHALL pulse, including a repeat of the held code (typematic).
REQ-022 A discarded frame SHALL NOT alter break_pending or key_code.
REQ-023 Timeout and falling edge in the same cycle: the edge wins, counter clears.

Reset
REQ-024 Reset low SHALL immediately force FSM IDLE, bit count 0, shift register 0, timeout 0, break_pending 0, synchronizers to 1, key_code 8'h00, key_strobe 0, frame_error 0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, decoding resumes at the next start bit.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN defined: a frame whose 8 data bits plus parity bit have even total ones SHALL be discarded with a frame_error pulse.
REQ-027 PS2_PARITY_CHECK_EN undefined: parity bit sampled and ignored; only stop-bit and timeout errors pulse frame_error.

Verification
REQ-028 Frame 8'h3C with odd parity, stop 1 -> key_code=8'h3C, key_strobe one pulse one cycle after stop.
REQ-029 Held 8'h3C, then frames F0, 3C -> key_code=8'h00 after second frame, no key_strobe.
REQ-030 Held 8'h3C, then frames F0, 1C -> key_code stays 8'h3C, break_pending cleared; next frame 1C -> key_code=8'h1C, strobe.
REQ-031 Frame 8'h3C with wrong parity -> with PS2_PARITY_CHECK_EN: frame_error pulse, key_code unchanged; without: key_code=8'h3C.
REQ-032 Start bit plus 4 data bits, then ps2_clk idle 50000 cycles -> frame_error pulse, FSM IDLE; next full frame 8'h1C decodes correctly.
REQ-033 Reset low during bit 5 of a frame -> all outputs 0 immediately; after release a full frame 8'h3C decodes to key_code=8'h3C.
